// File: rtl/alu_cmd_queue_if.sv
// Producer push handshake and registered ALU command bus of the ALU command queue.
interface alu_cmd_queue_if #(
    parameter int DW = 16
) ();
    logic          push_valid;
    logic [DW-1:0] push_A;
    logic [DW-1:0] push_B;
    logic [3:0]    push_opcode;
    logic          push_ready;
    logic [DW-1:0] alu_A;
    logic [DW-1:0] alu_B;
    logic [3:0]    alu_opcode;
    logic          alu_start;

    modport master (
        output push_valid, push_A, push_B, push_opcode,
        input  push_ready, alu_A, alu_B, alu_opcode, alu_start
    );

    modport slave (
        input  push_valid, push_A, push_B, push_opcode,
        output push_ready, alu_A, alu_B, alu_opcode, alu_start
    );
endinterface

// File: rtl/alu_cmd_queue.sv
// Command FIFO feeding a single ALU through an IDLE/ISSUE/WAIT issue engine.
// Operands are presented on registered outputs together with a one-cycle start pulse.
module alu_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_cmd_queue_if.slave           bus,
    input  logic                     flush,
    input  logic                     busy,
    input  logic                     diss_clk,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              issued_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * DW + 4;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            wait_first_r;
    logic [EW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_s;
    logic            push_ready_s;
    logic            push_go_s;
    logic            issue_go_s;
    logic [EW-1:0]   head_s;
    logic [DW-1:0]   alu_a_r;
    logic [DW-1:0]   alu_b_r;
    logic [3:0]      alu_opcode_r;
    logic            alu_start_r;
    logic [15:0]     issued_cnt_r;

    assign push_ready_s = (count_r != CNT_FULL);
    assign push_go_s    = bus.push_valid & push_ready_s & ~flush;
    assign head_s       = mem_r[rd_ptr_r];

    // Issue engine next state; issuing also pops the FIFO head.
    always_comb begin
        state_s    = state_r;
        issue_go_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((count_r != CNT_ZERO) && !busy && !diss_clk && !flush) begin
                    state_s    = ST_ISSUE;
                    issue_go_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // The ALU may not have raised busy yet in the first WAIT cycle.
                if (wait_first_r) begin
                    state_s = ST_WAIT;
                end else if (!busy) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_s = count_r;
        case ({push_go_s, issue_go_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // Issue engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            wait_first_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            wait_first_r <= (state_r == ST_ISSUE);
        end
    end

    // FIFO storage, pointers and occupancy; flush empties the queue in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
        end else if (flush) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_go_s) begin
                mem_r[wr_ptr_r] <= {bus.push_A, bus.push_B, bus.push_opcode};
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (issue_go_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_s;
        end
    end

    // Registered ALU command outputs; operands hold between issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r      <= {DW{1'b0}};
            alu_b_r      <= {DW{1'b0}};
            alu_opcode_r <= 4'd0;
            alu_start_r  <= 1'b0;
            issued_cnt_r <= 16'd0;
        end else begin
            alu_start_r <= issue_go_s;
            if (issue_go_s) begin
                alu_a_r      <= head_s[EW-1 -: DW];
                alu_b_r      <= head_s[DW+3 -: DW];
                alu_opcode_r <= head_s[3:0];
                issued_cnt_r <= issued_cnt_r + 16'd1;
            end else begin
                alu_a_r      <= alu_a_r;
                alu_b_r      <= alu_b_r;
                alu_opcode_r <= alu_opcode_r;
                issued_cnt_r <= issued_cnt_r;
            end
        end
    end

    assign bus.push_ready = push_ready_s;
    assign bus.alu_A      = alu_a_r;
    assign bus.alu_B      = alu_b_r;
    assign bus.alu_opcode = alu_opcode_r;
    assign bus.alu_start  = alu_start_r;
    assign count          = count_r;
    assign issued_cnt     = issued_cnt_r;
endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue: queue-based reference model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_alu_cmd_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 16;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        busy;
    logic        diss_clk;
    logic [2:0]  count;
    logic [15:0] issued_cnt;

    alu_cmd_queue_if #(.DW(DW)) bus ();

    alu_cmd_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .flush      (flush),
        .busy       (busy),
        .diss_clk   (diss_clk),
        .count      (count),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a plain command queue plus an "engine free" timer.
    logic [35:0] mq[$];
    bit          m_free;
    int          m_since;
    bit          m_pushed;
    logic        exp_start;
    logic [15:0] exp_a, exp_b;
    logic [3:0]  exp_op;
    logic [15:0] exp_issued;

    task automatic model_reset();
        mq.delete();
        m_free     = 1'b1;
        m_since    = 0;
        m_pushed   = 1'b0;
        exp_start  = 1'b0;
        exp_a      = 16'd0;
        exp_b      = 16'd0;
        exp_op     = 4'd0;
        exp_issued = 16'd0;
    endtask

    task automatic model_step();
        int          sz;
        bit          issue;
        logic [35:0] c;
        sz       = mq.size();
        issue    = m_free && (sz > 0) && !busy && !diss_clk && !flush;
        m_pushed = bus.push_valid && (sz < DEPTH) && !flush;
        if (!m_free) begin
            m_since++;
            // the engine returns to idle no earlier than 3 edges after an issue, then waits for busy low
            if (m_since >= 3 && !busy) m_free = 1'b1;
        end
        exp_start = issue;
        if (issue) begin
            c          = mq.pop_front();
            exp_a      = c[35:20];
            exp_b      = c[19:4];
            exp_op     = c[3:0];
            exp_issued = exp_issued + 16'd1;
            m_free     = 1'b0;
            m_since    = 0;
        end
        if (flush) mq.delete();
        else if (m_pushed) mq.push_back({bus.push_A, bus.push_B, bus.push_opcode});
    endtask

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("alu_start",  {31'd0, bus.alu_start}, {31'd0, exp_start});
            chk("alu_A",      {16'd0, bus.alu_A},     {16'd0, exp_a});
            chk("alu_B",      {16'd0, bus.alu_B},     {16'd0, exp_b});
            chk("alu_opcode", {28'd0, bus.alu_opcode}, {28'd0, exp_op});
            chk("count",      {29'd0, count},         mq.size());
            chk("issued_cnt", {16'd0, issued_cnt},    {16'd0, exp_issued});
            chk("push_ready", {31'd0, bus.push_ready}, {31'd0, (mq.size() != DEPTH)});
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst_n) model_step();
            @(negedge clk);
        end
    endtask

    task automatic push_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        bus.push_valid  = 1'b1;
        bus.push_A      = a;
        bus.push_B      = b;
        bus.push_opcode = op;
        tick(1);
        bus.push_valid  = 1'b0;
    endtask

    int   st_cyc[8];
    logic [15:0] st_a[8];
    int   nst;
    bit   seen;
    int   start_at;
    int   k;

    initial begin
        model_reset();
        rst_n = 1'b0; flush = 1'b0; busy = 1'b0; diss_clk = 1'b0;
        bus.push_valid = 1'b0; bus.push_A = 16'd0; bus.push_B = 16'd0; bus.push_opcode = 4'd0;
        tick(2);
        chk("reset_push_ready", {31'd0, bus.push_ready}, 32'd1);
        chk("reset_count", {29'd0, count}, 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Single command: start on the edge after the push edge, for exactly one cycle.
        push_cmd(16'h0003, 16'h0005, 4'h1);
        chk("single_count_after_push", {29'd0, count}, 32'd1);
        chk("single_no_early_start", {31'd0, bus.alu_start}, 32'd0);
        tick(1);
        chk("single_start", {31'd0, bus.alu_start}, 32'd1);
        chk("single_A", {16'd0, bus.alu_A}, 32'h3);
        chk("single_B", {16'd0, bus.alu_B}, 32'h5);
        chk("single_op", {28'd0, bus.alu_opcode}, 32'h1);
        chk("single_issued", {16'd0, issued_cnt}, 32'd1);
        tick(1);
        chk("single_start_one_cycle", {31'd0, bus.alu_start}, 32'd0);
        chk("single_A_hold", {16'd0, bus.alu_A}, 32'h3);
        tick(4);

        // Fill with issue blocked, fifth push rejected, then drain at full rate.
        diss_clk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_cmd(16'h0010 + 16'(i), 16'h0020 + 16'(i), 4'(i + 2));
            if (i == 3) begin
                chk("full_push_ready", {31'd0, bus.push_ready}, 32'd0);
                chk("full_count", {29'd0, count}, 32'd4);
            end
        end
        chk("fifth_rejected_count", {29'd0, count}, 32'd4);
        tick(3);
        diss_clk = 1'b0;
        nst = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (bus.alu_start && nst < 8) begin
                st_cyc[nst] = c;
                st_a[nst]   = bus.alu_A;
                nst++;
            end
        end
        chk("drain_num_starts", nst, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", {16'd0, st_a[i]}, 32'h10 + i);
            if (i > 0) chk("drain_spacing", st_cyc[i] - st_cyc[i-1], 32'd4);
        end
        chk("drain_first_latency", st_cyc[0], 32'd0);

        // Busy held after the first issue stalls the second.
        bus.push_valid = 1'b1; bus.push_A = 16'h0100; bus.push_B = 16'h0001; bus.push_opcode = 4'h3;
        tick(1);
        bus.push_A = 16'h0200; bus.push_B = 16'h0002; bus.push_opcode = 4'h4;
        tick(1);
        bus.push_valid = 1'b0;
        chk("busy_first_start", {31'd0, bus.alu_start}, 32'd1);
        chk("busy_first_A", {16'd0, bus.alu_A}, 32'h100);
        chk("busy_count_push_and_pop", {29'd0, count}, 32'd1);
        busy = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            seen = seen | bus.alu_start;
            chk("busy_wait_count", {29'd0, count}, 32'd1);
        end
        chk("busy_no_start", {31'd0, seen}, 32'd0);
        busy = 1'b0;
        start_at = -1;
        for (int c = 1; c <= 10; c++) begin
            tick(1);
            if (bus.alu_start && start_at < 0) begin
                start_at = c;
                chk("busy_second_A", {16'd0, bus.alu_A}, 32'h200);
            end
        end
        chk("busy_release_latency", start_at, 32'd2);

        // Flush with three queued and a concurrent push while a command is in flight.
        diss_clk = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(16'h0300 + 16'(i), 16'h0030, 4'h5);
        diss_clk = 1'b0;
        tick(1);
        chk("flush_inflight_start", {31'd0, bus.alu_start}, 32'd1);
        chk("flush_pre_count", {29'd0, count}, 32'd3);
        flush = 1'b1;
        bus.push_valid = 1'b1; bus.push_A = 16'h0BAD; bus.push_B = 16'h0BAD; bus.push_opcode = 4'hF;
        tick(1);
        flush = 1'b0;
        bus.push_valid = 1'b0;
        chk("flush_count", {29'd0, count}, 32'd0);
        chk("flush_inflight_A", {16'd0, bus.alu_A}, 32'h300);
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick(1);
            seen = seen | bus.alu_start;
        end
        chk("flush_no_issue", {31'd0, seen}, 32'd0);
        chk("flush_issued", {16'd0, issued_cnt}, 32'd8);

        // Asynchronous reset in the first WAIT cycle with two queued.
        diss_clk = 1'b1;
        for (int i = 0; i < 3; i++) push_cmd(16'h0400 + 16'(i), 16'h0040, 4'h6);
        diss_clk = 1'b0;
        tick(2);
        chk("rst_pre_count", {29'd0, count}, 32'd2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_alu_start", {31'd0, bus.alu_start}, 32'd0);
        chk("rst_alu_A", {16'd0, bus.alu_A}, 32'd0);
        chk("rst_alu_B", {16'd0, bus.alu_B}, 32'd0);
        chk("rst_alu_opcode", {28'd0, bus.alu_opcode}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_issued", {16'd0, issued_cnt}, 32'd0);
        chk("rst_push_ready", {31'd0, bus.push_ready}, 32'd1);
        tick(2);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            seen = seen | bus.alu_start;
        end
        chk("rst_no_issue_after", {31'd0, seen}, 32'd0);

        // Continuous streaming across several pointer wraps.
        k = 0;
        bus.push_valid = 1'b1;
        bus.push_A = 16'h0500; bus.push_B = 16'hFAFF; bus.push_opcode = 4'd0;
        for (int c = 0; c < 130; c++) begin
            tick(1);
            if (m_pushed && k < 22) begin
                k++;
                bus.push_A      = 16'h0500 + 16'(k);
                bus.push_B      = ~(16'h0500 + 16'(k));
                bus.push_opcode = 4'(k);
            end
            if (k == 22) bus.push_valid = 1'b0;
        end
        chk("stream_issued", {16'd0, issued_cnt}, 32'd22);
        chk("stream_last_A", {16'd0, bus.alu_A}, 32'h515);
        chk("stream_last_B", {16'd0, bus.alu_B}, 32'hFAEA);
        chk("stream_empty", {29'd0, count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth in entries (power of two, >=2).
REQ-002 Parameter DW, default 16, operand width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 push_valid  in  1  producer offers a command this cycle.
REQ-006 push_A, push_B  in  DW each  operands of offered command.
REQ-007 push_opcode  in  4  opcode of offered command.
REQ-008 push_ready  out  1  queue accepts a command this cycle (= not full).
REQ-009 flush  in  1  synchronous discard of all queued, not-yet-issued commands.
REQ-010 busy  in  1  ALU busy flag from downstream ALU.
REQ-011 diss_clk  in  1  ALU clock-dissipation request; high blocks new issues.
REQ-012 alu_A, alu_B  out  DW each  registered operands driven to ALU.
REQ-013 alu_opcode  out  4  registered opcode driven to ALU.
REQ-014 alu_start  out  1  registered one-cycle start pulse to ALU.
REQ-015 count  out  $clog2(DEPTH)+1  number of queued entries.
REQ-016 issued_cnt  out  16  total commands issued, wraps 16'hFFFF -> 0.

Function
REQ-017 Push accepted when push_valid=1, push_ready=1, flush=0; entry {A,B,opcode} written at tail; count +1 next cycle.
REQ-018 push_ready=0 when count==DEPTH; push in same cycle as pop while full is rejected (no full-bypass).
REQ-019 FSM states IDLE, ISSUE, WAIT; reset state IDLE.
REQ-020 IDLE -> ISSUE when count!=0, busy=0, diss_clk=0, flush=0; else stay IDLE.
REQ-021 On IDLE->ISSUE edge: alu_A/alu_B/alu_opcode load head entry, alu_start=1, head popped (count -1, concurrent push keeps count unchanged).
REQ-022 ISSUE lasts exactly one cycle, then WAIT unconditionally; alu_start=0 in every state except ISSUE; issued_cnt +1 on entering ISSUE.
REQ-023 WAIT ignores busy in its first cycle; from its second cycle, busy=0 -> IDLE.
REQ-024 alu_A/alu_B/alu_opcode hold last issued values outside ISSUE.
REQ-025 No empty-bypass: minimum push-to-alu_start latency 2 cycles (push edge, then issue edge).
REQ-026 Back-to-back: with busy held 0, successive alu_start pulses are 4 cycles apart (ISSUE, WAIT, WAIT, IDLE->ISSUE).
REQ-027 diss_clk only gates IDLE->ISSUE; diss_clk rising during ISSUE/WAIT does not abort the in-flight command.
REQ-028 flush=1: count -> 0, head/tail pointers equal next cycle; concurrent push discarded; in-flight command (ISSUE/WAIT) unaffected; FSM blocked from leaving IDLE that cycle.
REQ-029 Pointers wrap modulo DEPTH; FIFO order strictly preserved across wrap.
REQ-030 No ALU command issued while rst_n=0.

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, count 0, pointers 0, alu_start 0, alu_A/alu_B/alu_opcode 0, issued_cnt 0, push_ready 1 (combinational from count).
REQ-032 Reset asserted mid-WAIT or mid-ISSUE drops the command; FIFO contents discarded; no issue until two edges after rst_n release.

Verification
REQ-033 Single push A=16'h0003 B=16'h0005 opcode=4'h1, busy=0 -> alu_start high exactly 1 cycle, 2 cycles after push edge, alu_A=3 alu_B=5 alu_opcode=1, issued_cnt=1.
REQ-034 Push 5 commands at DEPTH=4 with diss_clk=1 -> push_ready=0 after 4th, 5th rejected, count=4, no alu_start; drop diss_clk -> 4 issues in push order, 4 cycles apart.
REQ-035 busy held 1 for 10 cycles after first issue, 2 queued -> second alu_start only after busy returns 0, count=1 throughout wait.
REQ-036 flush with count=3 and push_valid=1 in same cycle -> count=0 next cycle, pushed command never issued, in-flight op unaffected.
REQ-037 rst_n pulsed low during WAIT with count=2 -> all outputs reset values immediately, count=0, no alu_start afterwards without new pushes.
REQ-038 Push/issue 65537 commands -> issued_cnt wraps to 1; FIFO order correct across pointer wrap.
